// File: rtl/regfile_dump_reader_if.sv
// Debug dump channel: start/abort control, spare register-file read port and
// the {index, data} valid/ready stream plus status back to the debug side.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dump_csum;

    // Reader side: drives the RF address and the dump stream.
    modport master (
        input  start, abort, rf_data, dump_ready,
        output rf_addr, dump_valid, dump_index, dump_data, busy, done, dump_csum
    );

    // Debug/RF side: requests dumps, serves reads, consumes the stream.
    modport slave (
        output start, abort, rf_data, dump_ready,
        input  rf_addr, dump_valid, dump_index, dump_data, busy, done, dump_csum
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file via a spare async read port and streams {index, data} words.
// Latency: first word valid two edges after start; word held until dump_ready, abort drops it.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_dump_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_dump_index;
    logic [DATA_W-1:0] r_dump_data;
    logic [DATA_W-1:0] r_csum;
    logic [DATA_W-1:0] r_dump_csum;
    logic              r_dump_valid;

    logic              w_begin;
    logic              w_capture;
    logic              w_accept;
    logic              w_drop;
    logic              w_commit;
    logic              w_last;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Abort wins over a coincident handshake, so the word in flight is never counted.
    always_comb begin
        w_next_state = r_state;
        w_begin      = 1'b0;
        w_capture    = 1'b0;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_begin      = 1'b1;
                    w_next_state = S_READ;
                end
            end
            S_READ: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_capture    = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.abort) begin
                    w_drop       = 1'b1;
                    w_next_state = S_IDLE;
                end else if (bus.dump_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = w_last ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                w_commit     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_dump_index <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
            r_csum       <= '0;
            r_dump_csum  <= '0;
        end else begin
            if (w_begin) begin
                r_idx  <= '0;
                r_csum <= '0;
            end else if (w_accept && !w_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end

            if (w_capture) begin
                r_dump_data  <= bus.rf_data;
                r_dump_index <= r_idx;
                r_dump_valid <= 1'b1;
            end else if (w_accept || w_drop) begin
                r_dump_valid <= 1'b0;
            end

            if (w_accept) begin
                r_csum <= r_csum ^ r_dump_data;
            end

            // Published only once the whole dump is through; aborted runs leave it alone.
            if (w_commit) begin
                r_dump_csum <= r_csum;
            end
        end
    end

    assign bus.rf_addr    = r_idx;
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_index = r_dump_index;
    assign bus.dump_data  = r_dump_data;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.dump_csum  = r_dump_csum;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: scenario table with scoreboard of expected dump words.
module tb_regfile_dump_reader;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic [DATA_W-1:0] rf_mem [NUM_REGS];
    assign bus.rf_data = rf_mem[bus.rf_addr];

    regfile_dump_reader #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] dat;
    } word_t;
    word_t sb[$];

    typedef struct {
        int          stall_at;
        int          stall_len;
        int          restart_at;
        int          abort_at;
        int          wr_idx;
        logic [31:0] wr_val;
        int          exp_words;
        int          exp_done;
        int          exp_done_cyc;
        logic [31:0] exp_csum;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [DATA_W-1:0] base_val(input int k);
        return (k == 2) ? 32'h7fff_efe4 : 32'h0;
    endfunction

    task automatic rf_init();
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = base_val(i);
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        word_t w;
        word_t got;
        int first_valid, done_cyc, done_cnt, accepted, stall_cnt, idx;
        bit fin, aborted, done_seen, restarted;
        t = vecs[v];
        first_valid = -1; done_cyc = -1; done_cnt = 0; accepted = 0; stall_cnt = 0;
        fin = 0; aborted = 0; done_seen = 0; restarted = 0;
        sb.delete();
        for (int k = 0; k < t.exp_words; k++) begin
            w.idx = ADDR_W'(k);
            w.dat = (k == t.wr_idx) ? t.wr_val : base_val(k);
            sb.push_back(w);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b0; bus.dump_ready = 1'b1;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.abort = 1'b0; bus.dump_ready = 1'b1;
            if (aborted) begin
                check("abort_busy", bus.busy, 0);
                check("abort_valid", bus.dump_valid, 0);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    if (bus.done) done_cnt++;
                end
                fin = 1;
            end else if (done_seen) begin
                check("done_single_cycle", bus.done, 0);
                check("idle_after_done", bus.busy, 0);
                fin = 1;
            end else begin
                if (bus.done) begin
                    done_cnt++; done_cyc = cyc; done_seen = 1;
                end
                if (bus.dump_valid && first_valid < 0) first_valid = cyc;
                if (bus.dump_valid) begin
                    idx = int'(bus.dump_index);
                    if (idx == t.stall_at && stall_cnt < t.stall_len) begin
                        bus.dump_ready = 1'b0;
                        stall_cnt++;
                        if (sb.size() > 0) begin
                            check("stall_index", bus.dump_index, sb[0].idx);
                            check("stall_data", bus.dump_data, sb[0].dat);
                        end
                    end
                    if (idx == t.restart_at && !restarted) begin
                        bus.start = 1'b1; restarted = 1;
                    end
                    if (idx == t.abort_at) begin
                        bus.abort = 1'b1; aborted = 1;
                    end
                    if (t.wr_idx >= 0 && idx == t.wr_idx - 2) rf_mem[t.wr_idx] = t.wr_val;
                    if (bus.dump_ready && !bus.abort) begin
                        if (sb.size() == 0) begin
                            check("sb_underflow_index", bus.dump_index, '1);
                        end else begin
                            got = sb.pop_front();
                            check("word_index", bus.dump_index, got.idx);
                            check("word_data", bus.dump_data, got.dat);
                        end
                        accepted++;
                    end
                end
            end
        end
        check("vec_completed", fin, 1);
        check("words_accepted", accepted, t.exp_words);
        check("done_pulses", done_cnt, t.exp_done);
        check("first_valid_cyc", first_valid, 2);
        if (t.exp_done != 0) check("done_cyc", done_cyc, t.exp_done_cyc);
        check("dump_csum", bus.dump_csum, t.exp_csum);
        check("sb_empty", sb.size(), 0);
        bus.start = 1'b0; bus.abort = 1'b0;
        rf_init();
    endtask

    initial begin
        //            stall  len  rst  abrt  wr   wr_val        words done cyc  csum
        vecs[0] = '{-1,    0,  -1,  -1,  -1, 32'h0,        32,   1,   65, 32'h7fff_efe4};
        vecs[1] = '{ 5,   10,  -1,  -1,  -1, 32'h0,        32,   1,   75, 32'h7fff_efe4};
        vecs[2] = '{-1,    0,   7,  -1,  -1, 32'h0,        32,   1,   65, 32'h7fff_efe4};
        vecs[3] = '{-1,    0,  -1,  12,  -1, 32'h0,        12,   0,    0, 32'h7fff_efe4};
        vecs[4] = '{-1,    0,  -1,  -1,   9, 32'hDEAD_BEEF, 32,  1,   65, 32'hA152_510B};

        rf_init();
        bus.start = 1'b0; bus.abort = 1'b0; bus.dump_ready = 1'b0;
        #2 rst = 1'b1;
        #3;
        check("rst_rf_addr", bus.rf_addr, 0);
        check("rst_valid", bus.dump_valid, 0);
        check("rst_index", bus.dump_index, 0);
        check("rst_data", bus.dump_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_csum", bus.dump_csum, 0);
        @(negedge clk);
        rst = 1'b0;

        // start together with abort in IDLE must not launch a dump
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_stays_idle", bus.busy, 0);
        @(negedge clk);
        check("start_abort_no_valid", bus.dump_valid, 0);

        for (int v = 0; v < 5; v++) run_vec(v);

        // asynchronous reset between edges in the middle of a dump
        @(negedge clk);
        bus.start = 1'b1; bus.dump_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_reset_busy", bus.busy, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_valid", bus.dump_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_index", bus.dump_index, 0);
        check("midrst_data", bus.dump_data, 0);
        check("midrst_rf_addr", bus.rf_addr, 0);
        check("midrst_csum", bus.dump_csum, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_done", bus.done, 0);
        check("post_rst_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
